// File: rtl/change_hopper_if.sv
// Hopper controller bus: dispense handshake, drop sensor, refill and fault service signals.
// The master side is the upstream/operator logic; the slave side is the hopper controller.
interface change_hopper_if #(
  parameter int unsigned STOCK_W = 8
) ();
  logic               change_emit_dime;
  logic               change_done;
  logic               hopper_sol_r;
  logic               hopper_sensor;
  logic               refill_valid;
  logic [STOCK_W-1:0] refill_count;
  logic [STOCK_W-1:0] stock_r;
  logic               empty_r;
  logic               fault_r;
  logic [1:0]         fault_code_r;
  logic               fault_clear;

  modport master (
    output change_emit_dime, hopper_sensor, refill_valid, refill_count, fault_clear,
    input  change_done, hopper_sol_r, stock_r, empty_r, fault_r, fault_code_r
  );

  modport slave (
    input  change_emit_dime, hopper_sensor, refill_valid, refill_count, fault_clear,
    output change_done, hopper_sol_r, stock_r, empty_r, fault_r, fault_code_r
  );
endinterface

// File: rtl/change_hopper_ctrl.sv
// Dime hopper controller: turns a one-cycle emit request into a timed solenoid pulse,
// confirms the drop on a debounced sensor, tracks stock and latches faults until cleared.
module change_hopper_ctrl #(
  parameter int unsigned SOL_CYCLES      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter int unsigned STOCK_W         = 8,
  parameter int unsigned STOCK_INIT      = 100
) (
  input logic             clk,
  input logic             rst_n,
  change_hopper_if.slave  bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFire,
    StSense,
    StRelease,
    StDone,
    StFault
  } state_e;

  typedef enum logic [1:0] {
    FcNone  = 2'd0,
    FcEmpty = 2'd1,
    FcJam   = 2'd2,
    FcStuck = 2'd3
  } fault_code_e;

  state_e              state_q, state_d;
  fault_code_e         code_q, code_d;
  logic [CntW-1:0]     timer_q;
  logic [CntW-1:0]     deb_q;
  logic                sol_q, done_q, fault_q;
  logic [STOCK_W-1:0]  stock_q, stock_d;
  logic                empty_q;
  logic [STOCK_W:0]    stock_sum;
  logic                timer_last;
  logic                deb_last;
  logic                stock_dec;

  // Next-state and fault-code decode; sensor is only looked at in SENSE and RELEASE.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    timer_last = (timer_q == CntW'(TIMEOUT_CYCLES - 1));
    deb_last   = bus.hopper_sensor && (deb_q == CntW'(DEBOUNCE_CYCLES - 1));
    case (state_q)
      StIdle: begin
        if (bus.change_emit_dime) begin
          if (stock_q != '0) begin
            state_d = StFire;
          end else begin
            state_d = StFault;
            code_d  = FcEmpty;
          end
        end
      end
      StFire: begin
        if (timer_q == CntW'(SOL_CYCLES - 1)) state_d = StSense;
      end
      StSense: begin
        // A confirm landing on the same edge as the timeout wins.
        if (deb_last) begin
          state_d = StRelease;
        end else if (timer_last) begin
          state_d = StFault;
          code_d  = FcJam;
        end
      end
      StRelease: begin
        if (!bus.hopper_sensor) begin
          state_d = StDone;
        end else if (timer_last) begin
          state_d = StFault;
          code_d  = FcStuck;
        end
      end
      StDone: state_d = StIdle;
      StFault: begin
        if (bus.fault_clear) begin
          state_d = StIdle;
          code_d  = FcNone;
        end
      end
      default: begin
        state_d = StIdle;
        code_d  = FcNone;
      end
    endcase
  end

  // FSM state, per-state timer/debounce counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= FcNone;
      timer_q <= '0;
      deb_q   <= '0;
      sol_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      sol_q   <= (state_d == StFire);
      done_q  <= (state_d == StDone);
      fault_q <= (state_d == StFault);
      if (state_d != state_q) begin
        timer_q <= '0;
        deb_q   <= '0;
      end else begin
        if (state_q == StFire || state_q == StSense || state_q == StRelease) begin
          timer_q <= timer_q + CntW'(1);
        end
        if (state_q == StSense) begin
          deb_q <= bus.hopper_sensor ? deb_q + CntW'(1) : '0;
        end
      end
    end
  end

  // Stock arithmetic: decrement on DONE plus optional refill, saturating at all-ones.
  // DONE is only reachable with stock >= 1, so the subtraction cannot wrap.
  always_comb begin
    stock_dec = (state_q == StDone);
    stock_sum = {1'b0, stock_q}
              + (bus.refill_valid ? {1'b0, bus.refill_count} : {(STOCK_W + 1){1'b0}})
              - {{STOCK_W{1'b0}}, stock_dec};
    stock_d   = stock_sum[STOCK_W] ? {STOCK_W{1'b1}} : stock_sum[STOCK_W-1:0];
  end

  // Stock register and its registered empty flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stock_q <= STOCK_W'(STOCK_INIT);
      empty_q <= (STOCK_INIT == 0);
    end else begin
      stock_q <= stock_d;
      empty_q <= (stock_d == '0);
    end
  end

  assign bus.change_done  = done_q;
  assign bus.hopper_sol_r = sol_q;
  assign bus.stock_r      = stock_q;
  assign bus.empty_r      = empty_q;
  assign bus.fault_r      = fault_q;
  assign bus.fault_code_r = code_q;

endmodule

// File: tb/tb_change_hopper_ctrl.sv
// Self-checking bench for change_hopper_ctrl: expected change_done cycles are queued when a
// dispense is launched and popped when the pulse is observed.
module tb_change_hopper_ctrl;

  localparam int unsigned SolCycles  = 4;
  localparam int unsigned DebCycles  = 3;
  localparam int unsigned TimeoutCyc = 64;
  localparam int unsigned StockW     = 8;
  localparam int unsigned StockInit  = 100;
  localparam int unsigned StockMax   = (1 << StockW) - 1;

  logic clk;
  logic rst_n;

  change_hopper_if #(.STOCK_W(StockW)) bus ();

  change_hopper_ctrl #(
    .SOL_CYCLES      (SolCycles),
    .DEBOUNCE_CYCLES (DebCycles),
    .TIMEOUT_CYCLES  (TimeoutCyc),
    .STOCK_W         (StockW),
    .STOCK_INIT      (StockInit)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int sol_total  = 0;
  int model_stock;
  int exp_done_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and run the output monitor/scoreboard.
  task automatic tick();
    int e;
    @(negedge clk);
    cyc++;
    if (bus.hopper_sol_r) sol_total++;
    if (bus.change_done) begin
      if (exp_done_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = exp_done_q.pop_front();
        check("done_cycle", cyc, e);
      end
    end
  endtask

  task automatic drive_sensor(input bit v, input int n);
    bus.hopper_sensor = v;
    repeat (n) tick();
  endtask

  function automatic int sat(input int v);
    return (v > int'(StockMax)) ? int'(StockMax) : v;
  endfunction

  // One full dispense. pre_hi/gap add a short glitch before the real confirm, extra_req
  // inserts an idle SENSE cycle carrying a second request, done_refill refills in DONE.
  task automatic dispense(input int pre_hi, input int gap, input bit extra_req,
                          input int done_refill);
    int c;
    int sol0;
    c    = cyc;
    sol0 = sol_total;
    exp_done_q.push_back(c + int'(SolCycles + DebCycles) + 2 + pre_hi + gap + int'(extra_req));
    bus.change_emit_dime = 1'b1;
    tick();
    bus.change_emit_dime = 1'b0;
    repeat (SolCycles) tick();
    if (extra_req) begin
      bus.change_emit_dime = 1'b1;
      bus.hopper_sensor    = 1'b0;
      tick();
      bus.change_emit_dime = 1'b0;
    end
    if (pre_hi > 0) begin
      drive_sensor(1'b1, pre_hi);
      drive_sensor(1'b0, gap);
    end
    drive_sensor(1'b1, DebCycles);
    drive_sensor(1'b0, 1);
    bus.refill_valid = (done_refill != 0);
    bus.refill_count = StockW'(done_refill);
    tick();
    bus.refill_valid = 1'b0;
    bus.refill_count = '0;
    tick();
    model_stock = sat(model_stock - 1 + done_refill);
    check("sol_pulse_len", sol_total - sol0, SolCycles);
    check("stock_after", int'(bus.stock_r), model_stock);
    check("empty_after", int'(bus.empty_r), int'(model_stock == 0));
    check("no_requeue_sol", int'(bus.hopper_sol_r), 0);
    check("no_fault", int'(bus.fault_r), 0);
  endtask

  task automatic wait_fault(input int limit);
    int n;
    n = 0;
    while (!bus.fault_r && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic clear_fault();
    bus.fault_clear = 1'b1;
    tick();
    bus.fault_clear = 1'b0;
    check("clear_fault_r", int'(bus.fault_r), 0);
    check("clear_code", int'(bus.fault_code_r), 0);
  endtask

  initial begin
    int c;
    int sol0;
    rst_n                = 1'b0;
    bus.change_emit_dime = 1'b0;
    bus.hopper_sensor    = 1'b0;
    bus.refill_valid     = 1'b0;
    bus.refill_count     = '0;
    bus.fault_clear      = 1'b0;
    model_stock          = StockInit;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset values.
    check("rst_sol", int'(bus.hopper_sol_r), 0);
    check("rst_done", int'(bus.change_done), 0);
    check("rst_fault", int'(bus.fault_r), 0);
    check("rst_code", int'(bus.fault_code_r), 0);
    check("rst_stock", int'(bus.stock_r), StockInit);
    check("rst_empty", int'(bus.empty_r), 0);
    tick();

    // Nominal and glitch.
    dispense(0, 0, 1'b0, 0);
    dispense(2, 1, 1'b0, 0);

    // Jam: sensor stays low, fault one timeout after SENSE entry.
    c = cyc;
    bus.change_emit_dime = 1'b1;
    tick();
    bus.change_emit_dime = 1'b0;
    wait_fault(200);
    check("jam_fault_cycle", cyc, c + int'(SolCycles) + 1 + int'(TimeoutCyc));
    check("jam_code", int'(bus.fault_code_r), 2);
    // Requests in FAULT, and a request alongside the clear, are dropped.
    sol0 = sol_total;
    bus.change_emit_dime = 1'b1;
    tick();
    bus.change_emit_dime = 1'b1;
    bus.fault_clear      = 1'b1;
    tick();
    bus.change_emit_dime = 1'b0;
    bus.fault_clear      = 1'b0;
    check("jam_cleared", int'(bus.fault_r), 0);
    repeat (6) tick();
    check("fault_req_ignored", sol_total - sol0, 0);
    dispense(0, 0, 1'b0, 0);

    // Stuck: sensor high from FIRE onwards (ignored there), never falls in RELEASE.
    c = cyc;
    bus.change_emit_dime = 1'b1;
    tick();
    bus.change_emit_dime = 1'b0;
    bus.hopper_sensor    = 1'b1;
    wait_fault(300);
    check("stuck_fault_cycle", cyc,
          c + int'(SolCycles) + 1 + int'(DebCycles) + int'(TimeoutCyc));
    check("stuck_code", int'(bus.fault_code_r), 3);
    bus.hopper_sensor = 1'b0;
    clear_fault();
    check("stuck_stock_kept", int'(bus.stock_r), model_stock);

    // Drain to zero; the last dispense takes stock 1 -> 0.
    while (model_stock > 0) dispense(0, 0, 1'b0, 0);

    // Empty: request at zero stock faults with EMPTY and never fires.
    sol0 = sol_total;
    bus.change_emit_dime = 1'b1;
    tick();
    bus.change_emit_dime = 1'b0;
    check("empty_fault", int'(bus.fault_r), 1);
    check("empty_code", int'(bus.fault_code_r), 1);
    repeat (5) tick();
    check("empty_no_sol", sol_total - sol0, 0);
    clear_fault();

    // Refill to 254, then a refill of 5 in the DONE cycle saturates at 255.
    bus.refill_valid = 1'b1;
    bus.refill_count = StockW'(254);
    tick();
    bus.refill_valid = 1'b0;
    bus.refill_count = '0;
    model_stock = sat(model_stock + 254);
    check("refill_stock", int'(bus.stock_r), model_stock);
    check("refill_empty", int'(bus.empty_r), 0);
    dispense(0, 0, 1'b0, 5);

    // Reset in the middle of FIRE.
    bus.change_emit_dime = 1'b1;
    tick();
    bus.change_emit_dime = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_stock = StockInit;
    check("midrst_sol", int'(bus.hopper_sol_r), 0);
    check("midrst_stock", int'(bus.stock_r), StockInit);
    check("midrst_fault", int'(bus.fault_r), 0);
    sol0 = sol_total;
    repeat (10) tick();
    check("midrst_idle", sol_total - sol0, 0);

    // Second request during SENSE is dropped: exactly one done.
    dispense(0, 0, 1'b1, 0);
    repeat (SolCycles + 4) tick();

    check("sb_drain", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
